lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
Memory-stage load/store controller between the EX/MEM pipeline register and the word-organised data memory wrapper.
- Accepts one load/store request at a time.
- Validates funct3, alignment and address range.
- Splits the byte address into a word index and a byte lane, and drives the memory's en/load_store/byteadd/func/addr/wdata interface.
- Returns load data, or a store-done / fault indication, to writeback with fixed latency.

Parameters:
d_width, 32, data width of the store data, load data and memory word.
a_width, 8, word-index width of the data memory (2^a_width words).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  request present from EX/MEM.
req_ready  output  1  controller can accept a request (high only in IDLE).
req_store  input  1  1 = store, 0 = load.
req_funct3  input  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
req_addr  input  32  effective byte address.
req_wdata  input  d_width  store data, unshifted (low bits used for SB/SH).
req_rd  input  5  load destination register.
dmem_en  output  1  memory enable.
dmem_load_store  output  1  1 = write, 0 = read.
dmem_byteadd  output  2  byte lane, req_addr[1:0].
dmem_func  output  3  funct3 forwarded to memory.
dmem_addr  output  a_width  word index, req_addr[a_width+1:2].
dmem_wdata  output  d_width  store data.
dmem_rdata  input  d_width  registered read data; valid the cycle after a read-enable cycle.
wb_valid  output  1  one-cycle completion pulse.
wb_we  output  1  write rd (load completed without fault).
wb_rd  output  5  destination register.
wb_data  output  d_width  load result.
wb_err  output  1  request faulted; no memory access was made.
wb_err_cause  output  2  01 illegal funct3, 10 misaligned, 11 out of range, 00 none.
wb_err_addr  output  32  faulting byte address.

Behaviour:
- States: IDLE, ISSUE, RESP, ERR. req_ready = (state==IDLE). Accept = req_valid & req_ready.
- Reset (asynchronous, any state): state=IDLE. All outputs go to 0 (wb_*, dmem_*, wb_err_cause, wb_err_addr). The captured request registers clear. No memory write is issued after reset is asserted.
- On accept, register req_store, req_funct3, req_addr, req_wdata and req_rd, then run the checks. Checks are evaluated in this priority order:
  1. Illegal funct3. For a load, any funct3 in {011,110,111}. For a store, any funct3 > 010.
  2. Misaligned. Halfword with addr[0]=1, or word with addr[1:0]!=00.
  3. Out of range. req_addr[31:a_width+2] != 0.
- Transitions:
  - IDLE, accept with a fault -> ERR.
  - IDLE, accept with no fault -> ISSUE.
  - ISSUE -> RESP.
  - RESP -> IDLE.
  - ERR -> IDLE.
- ISSUE: dmem_en=1, dmem_load_store=captured store, dmem_byteadd=addr[1:0], dmem_addr=addr[a_width+1:2], dmem_func=funct3, dmem_wdata=captured wdata. These are registered outputs. In every other state dmem_en=0 and the other dmem_* outputs hold their previous values.
- RESP: wb_valid=1 and wb_rd=captured rd.
  - Load: wb_we=1 and wb_data=dmem_rdata, passed through combinationally in RESP.
  - Store: wb_we=0 and wb_data=0.
- ERR: wb_valid=1, wb_err=1, wb_we=0, wb_err_cause and wb_err_addr per the checks. dmem_en stays 0.
- Latency: accept at cycle T -> memory access at T+1 -> wb_valid at T+2. A fault gives wb_valid at T+1. Maximum throughput is one request per 3 cycles, or per 2 cycles for faults.
- wb_valid, wb_err and wb_we are single-cycle pulses. wb_err_cause is 00 whenever wb_err=0.
- A req_valid held high while req_ready=0 is ignored. The request is taken on the first IDLE cycle; there is no loss and no duplication.
- Boundary: byte address (2^a_width*4)-1 is legal for byte access; (2^a_width*4) is out of range. Store data is passed to memory unshifted; byte-lane steering is the memory's job.

Test Plan:
- LW at addr 0x010 after SW 0xDEADBEEF to 0x010 -> store: dmem_en at T+1 with dmem_addr=4, wb_valid at T+2 with wb_we=0. Load: wb_data=0xDEADBEEF, wb_we=1 at T+2.
- SB 0x7F to 0x013, then LB 0x013 and LBU 0x013 after storing 0x80 -> dmem_byteadd=3. LB returns 0xFFFFFF80; LBU returns 0x00000080.
- LH at 0x011 -> wb_valid+wb_err at T+1, cause=10, wb_err_addr=0x011, dmem_en never 1. LW at 0x402 -> cause=10 (misaligned outranks range).
- LW at 0x400 (a_width=8) -> cause=11, no memory access. Load with funct3=011 -> cause=01.
- req_valid held high continuously with alternating SW/LW -> req_ready=1 only every 3rd cycle, and each request completes exactly once, in order.
- rst_n dropped during ISSUE of an SW to 0x020 -> all outputs 0 immediately, state IDLE. After release, LW 0x020 returns 0 (memory also reset).

Source files
------------

// File: rtl/lsu_mem_ctrl_if.sv
// Load/store controller bus bundle: EX/MEM request, data-memory port and
// writeback response. The controller uses the slave view; the pipeline/memory
// side (or a testbench) uses the master view.
interface lsu_mem_ctrl_if #(
  parameter int unsigned d_width = 32,
  parameter int unsigned a_width = 8
);
  // EX/MEM request
  logic               req_valid;
  logic               req_ready;
  logic               req_store;
  logic [2:0]         req_funct3;
  logic [31:0]        req_addr;
  logic [d_width-1:0] req_wdata;
  logic [4:0]         req_rd;

  // Data memory wrapper
  logic               dmem_en;
  logic               dmem_load_store;
  logic [1:0]         dmem_byteadd;
  logic [2:0]         dmem_func;
  logic [a_width-1:0] dmem_addr;
  logic [d_width-1:0] dmem_wdata;
  logic [d_width-1:0] dmem_rdata;

  // Writeback response
  logic               wb_valid;
  logic               wb_we;
  logic [4:0]         wb_rd;
  logic [d_width-1:0] wb_data;
  logic               wb_err;
  logic [1:0]         wb_err_cause;
  logic [31:0]        wb_err_addr;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
    input  dmem_rdata,
    output req_ready,
    output dmem_en, dmem_load_store, dmem_byteadd, dmem_func, dmem_addr, dmem_wdata,
    output wb_valid, wb_we, wb_rd, wb_data, wb_err, wb_err_cause, wb_err_addr
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
    output dmem_rdata,
    input  req_ready,
    input  dmem_en, dmem_load_store, dmem_byteadd, dmem_func, dmem_addr, dmem_wdata,
    input  wb_valid, wb_we, wb_rd, wb_data, wb_err, wb_err_cause, wb_err_addr
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Memory-stage load/store controller. Takes one request at a time, checks
// funct3 / alignment / range, issues a single registered access to the
// word-organised data memory and returns a one-cycle writeback pulse.
module lsu_mem_ctrl #(
  parameter int unsigned d_width = 32,
  parameter int unsigned a_width = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  lsu_mem_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;
  localparam logic [1:0] ERR   = 2'd3;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_F3    = 2'b01;
  localparam logic [1:0] CAUSE_ALIGN = 2'b10;
  localparam logic [1:0] CAUSE_RANGE = 2'b11;

  logic [1:0]         state_q, state_d;
  logic               store_q, store_d;
  logic [31:0]        addr_q, addr_d;
  logic [4:0]         rd_q, rd_d;
  logic [1:0]         cause_q, cause_d;

  logic               dmem_en_q, dmem_en_d;
  logic               dmem_ls_q, dmem_ls_d;
  logic [1:0]         dmem_byteadd_q, dmem_byteadd_d;
  logic [2:0]         dmem_func_q, dmem_func_d;
  logic [a_width-1:0] dmem_addr_q, dmem_addr_d;
  logic [d_width-1:0] dmem_wdata_q, dmem_wdata_d;

  logic               accept;
  logic               f3_illegal;
  logic               misaligned;
  logic               out_of_range;
  logic [1:0]         req_cause;

  assign accept = bus.req_valid && (state_q == IDLE);

  // Fault classification of the incoming request, highest priority first
  always_comb begin
    if (bus.req_store) begin
      f3_illegal = (bus.req_funct3 > 3'b010);
    end else begin
      f3_illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                   (bus.req_funct3 == 3'b111);
    end
    misaligned   = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                   ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    out_of_range = ((bus.req_addr >> (a_width + 2)) != 32'd0);
    if (f3_illegal) begin
      req_cause = CAUSE_F3;
    end else if (misaligned) begin
      req_cause = CAUSE_ALIGN;
    end else if (out_of_range) begin
      req_cause = CAUSE_RANGE;
    end else begin
      req_cause = CAUSE_NONE;
    end
  end

  // Next-state, request capture and memory-port register loading.
  // The dmem_* registers are loaded on the accepting edge so the access is
  // already on the port during ISSUE; they hold their value elsewhere.
  always_comb begin
    state_d        = state_q;
    store_d        = store_q;
    addr_d         = addr_q;
    rd_d           = rd_q;
    cause_d        = cause_q;
    dmem_en_d      = 1'b0;
    dmem_ls_d      = dmem_ls_q;
    dmem_byteadd_d = dmem_byteadd_q;
    dmem_func_d    = dmem_func_q;
    dmem_addr_d    = dmem_addr_q;
    dmem_wdata_d   = dmem_wdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          store_d = bus.req_store;
          addr_d  = bus.req_addr;
          rd_d    = bus.req_rd;
          cause_d = req_cause;
          if (req_cause != CAUSE_NONE) begin
            state_d = ERR;
          end else begin
            state_d        = ISSUE;
            dmem_en_d      = 1'b1;
            dmem_ls_d      = bus.req_store;
            dmem_byteadd_d = bus.req_addr[1:0];
            dmem_func_d    = bus.req_funct3;
            dmem_addr_d    = bus.req_addr[a_width+1:2];
            dmem_wdata_d   = bus.req_wdata;
          end
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and captured-request registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      store_q        <= 1'b0;
      addr_q         <= '0;
      rd_q           <= '0;
      cause_q        <= CAUSE_NONE;
      dmem_en_q      <= 1'b0;
      dmem_ls_q      <= 1'b0;
      dmem_byteadd_q <= '0;
      dmem_func_q    <= '0;
      dmem_addr_q    <= '0;
      dmem_wdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      store_q        <= store_d;
      addr_q         <= addr_d;
      rd_q           <= rd_d;
      cause_q        <= cause_d;
      dmem_en_q      <= dmem_en_d;
      dmem_ls_q      <= dmem_ls_d;
      dmem_byteadd_q <= dmem_byteadd_d;
      dmem_func_q    <= dmem_func_d;
      dmem_addr_q    <= dmem_addr_d;
      dmem_wdata_q   <= dmem_wdata_d;
    end
  end

  assign bus.req_ready       = (state_q == IDLE);
  assign bus.dmem_en         = dmem_en_q;
  assign bus.dmem_load_store = dmem_ls_q;
  assign bus.dmem_byteadd    = dmem_byteadd_q;
  assign bus.dmem_func       = dmem_func_q;
  assign bus.dmem_addr       = dmem_addr_q;
  assign bus.dmem_wdata      = dmem_wdata_q;

  // Writeback decode: pulses in RESP/ERR, load data passed straight through
  always_comb begin
    bus.wb_valid     = 1'b0;
    bus.wb_we        = 1'b0;
    bus.wb_rd        = '0;
    bus.wb_data      = '0;
    bus.wb_err       = 1'b0;
    bus.wb_err_cause = CAUSE_NONE;
    bus.wb_err_addr  = '0;
    case (state_q)
      RESP: begin
        bus.wb_valid = 1'b1;
        bus.wb_rd    = rd_q;
        if (!store_q) begin
          bus.wb_we   = 1'b1;
          bus.wb_data = bus.dmem_rdata;
        end
      end
      ERR: begin
        bus.wb_valid     = 1'b1;
        bus.wb_rd        = rd_q;
        bus.wb_err       = 1'b1;
        bus.wb_err_cause = cause_q;
        bus.wb_err_addr  = addr_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a behavioural byte-lane data memory.
module tb_lsu_mem_ctrl;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;
  int   n_fail;
  int   n_wb;

  lsu_mem_ctrl_if #(.d_width(32), .a_width(8)) bus ();

  lsu_mem_ctrl #(.d_width(32), .a_width(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model: registered read with sign/zero extension by func,
  // byte/halfword/word writes by lane, cleared by reset.
  logic [31:0] mem [0:255];

  function automatic logic [31:0] rd_fmt(input logic [31:0] w, input logic [2:0] f,
                                         input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*lane +: 8];
    h = w[16*lane[1] +: 16];
    case (f)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      bus.dmem_rdata <= '0;
    end else if (bus.dmem_en) begin
      if (bus.dmem_load_store) begin
        case (bus.dmem_func[1:0])
          2'b00:   mem[bus.dmem_addr][8*bus.dmem_byteadd +: 8]     <= bus.dmem_wdata[7:0];
          2'b01:   mem[bus.dmem_addr][16*bus.dmem_byteadd[1] +: 16] <= bus.dmem_wdata[15:0];
          default: mem[bus.dmem_addr] <= bus.dmem_wdata;
        endcase
      end else begin
        bus.dmem_rdata <= rd_fmt(mem[bus.dmem_addr], bus.dmem_func, bus.dmem_byteadd);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request from IDLE (entered at posedge+1) through its writeback pulse.
  task automatic run_req(input string tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [1:0] ecause,
                         input logic [31:0] edata);
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_rd     = rd;
    @(negedge clk);
    chk({tag, ".ready"}, bus.req_ready, 1'b1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (ecause == 2'b00) begin
      @(negedge clk);
      chk({tag, ".issue_en"}, bus.dmem_en, 1'b1);
      chk({tag, ".issue_ls"}, bus.dmem_load_store, st);
      chk({tag, ".issue_addr"}, bus.dmem_addr, addr[9:2]);
      chk({tag, ".issue_lane"}, bus.dmem_byteadd, addr[1:0]);
      chk({tag, ".issue_func"}, bus.dmem_func, f3);
      if (st) chk({tag, ".issue_wdata"}, bus.dmem_wdata, wd);
      chk({tag, ".issue_wbv"}, bus.wb_valid, 1'b0);
      @(negedge clk);
      chk({tag, ".wb_valid"}, bus.wb_valid, 1'b1);
      chk({tag, ".wb_we"}, bus.wb_we, !st);
      chk({tag, ".wb_rd"}, bus.wb_rd, rd);
      chk({tag, ".wb_data"}, bus.wb_data, edata);
      chk({tag, ".wb_err"}, bus.wb_err, 1'b0);
      chk({tag, ".cause"}, bus.wb_err_cause, 2'b00);
      chk({tag, ".resp_en"}, bus.dmem_en, 1'b0);
    end else begin
      @(negedge clk);
      chk({tag, ".wb_valid"}, bus.wb_valid, 1'b1);
      chk({tag, ".wb_err"}, bus.wb_err, 1'b1);
      chk({tag, ".cause"}, bus.wb_err_cause, ecause);
      chk({tag, ".err_addr"}, bus.wb_err_addr, addr);
      chk({tag, ".wb_we"}, bus.wb_we, 1'b0);
      chk({tag, ".no_access"}, bus.dmem_en, 1'b0);
    end
    @(posedge clk); #1;
    chk({tag, ".pulse_end"}, bus.wb_valid, 1'b0);
    chk({tag, ".idle_en"}, bus.dmem_en, 1'b0);
  endtask

  logic        s_st;
  logic [31:0] s_addr, s_data, s_exp;

  initial begin
    n_total = 0; n_pass = 0; n_fail = 0; n_wb = 0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_rd = '0;

    #12;
    chk("rst.ready", bus.req_ready, 1'b1);
    chk("rst.dmem_en", bus.dmem_en, 1'b0);
    chk("rst.dmem_addr", bus.dmem_addr, 8'h00);
    chk("rst.wb_valid", bus.wb_valid, 1'b0);
    chk("rst.wb_err", bus.wb_err, 1'b0);
    chk("rst.cause", bus.wb_err_cause, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Word store then load back
    run_req("sw10", 1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 5'd0, 2'b00, 32'h0);
    run_req("lw10", 1'b0, 3'b010, 32'h010, 32'h0, 5'd5, 2'b00, 32'hDEADBEEF);
    // Byte lane 3, store data unshifted
    run_req("sb13a", 1'b1, 3'b000, 32'h013, 32'hAAAAAA7F, 5'd0, 2'b00, 32'h0);
    run_req("lb13a", 1'b0, 3'b000, 32'h013, 32'h0, 5'd6, 2'b00, 32'h0000007F);
    run_req("sb13b", 1'b1, 3'b000, 32'h013, 32'h00000080, 5'd0, 2'b00, 32'h0);
    run_req("lb13b", 1'b0, 3'b000, 32'h013, 32'h0, 5'd7, 2'b00, 32'hFFFFFF80);
    run_req("lbu13", 1'b0, 3'b100, 32'h013, 32'h0, 5'd8, 2'b00, 32'h00000080);
    run_req("lw10b", 1'b0, 3'b010, 32'h010, 32'h0, 5'd9, 2'b00, 32'h80ADBEEF);
    run_req("lhu12", 1'b0, 3'b101, 32'h012, 32'h0, 5'd10, 2'b00, 32'h000080AD);
    run_req("lh12", 1'b0, 3'b001, 32'h012, 32'h0, 5'd11, 2'b00, 32'hFFFF80AD);
    // Faults and priority
    run_req("lh11", 1'b0, 3'b001, 32'h011, 32'h0, 5'd1, 2'b10, 32'h0);
    run_req("lw402", 1'b0, 3'b010, 32'h402, 32'h0, 5'd1, 2'b10, 32'h0);
    run_req("lw400", 1'b0, 3'b010, 32'h400, 32'h0, 5'd1, 2'b11, 32'h0);
    run_req("ld_f3", 1'b0, 3'b011, 32'h000, 32'h0, 5'd1, 2'b01, 32'h0);
    run_req("st_f3", 1'b1, 3'b100, 32'h000, 32'h1, 5'd1, 2'b01, 32'h0);
    run_req("f3_rng", 1'b0, 3'b110, 32'h1000, 32'h0, 5'd1, 2'b01, 32'h0);
    run_req("sh3", 1'b1, 3'b001, 32'h003, 32'h1, 5'd1, 2'b10, 32'h0);
    run_req("sw_hi", 1'b1, 3'b010, 32'h8000_0000, 32'h1, 5'd1, 2'b11, 32'h0);
    // Range boundary for byte access
    run_req("sb3ff", 1'b1, 3'b000, 32'h3FF, 32'h000000C3, 5'd0, 2'b00, 32'h0);
    run_req("lbu3ff", 1'b0, 3'b100, 32'h3FF, 32'h0, 5'd12, 2'b00, 32'h000000C3);
    run_req("lb400", 1'b0, 3'b000, 32'h400, 32'h0, 5'd12, 2'b11, 32'h0);

    // Back-to-back requests with req_valid held high: one per 3 cycles
    bus.req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_st   = (i % 2 == 0);
      s_addr = (i < 2) ? 32'h040 : 32'h044;
      s_data = (i < 2) ? 32'hCAFE0001 : 32'h0BAD0002;
      s_exp  = s_st ? 32'h0 : s_data;
      bus.req_store  = s_st;
      bus.req_funct3 = 3'b010;
      bus.req_addr   = s_addr;
      bus.req_wdata  = s_st ? s_data : 32'h0;
      bus.req_rd     = 5'd20 + 5'(i);
      @(negedge clk);
      chk("stream.ready_idle", bus.req_ready, 1'b1);
      if (bus.wb_valid) n_wb++;
      @(posedge clk); #1;
      @(negedge clk);
      chk("stream.ready_issue", bus.req_ready, 1'b0);
      chk("stream.issue_addr", bus.dmem_addr, s_addr[9:2]);
      chk("stream.issue_ls", bus.dmem_load_store, s_st);
      if (bus.wb_valid) n_wb++;
      @(posedge clk); #1;
      @(negedge clk);
      chk("stream.ready_resp", bus.req_ready, 1'b0);
      chk("stream.wb_data", bus.wb_data, s_exp);
      chk("stream.wb_rd", bus.wb_rd, 5'd20 + 5'(i));
      if (bus.wb_valid) n_wb++;
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
    if (bus.wb_valid) n_wb++;
    chk("stream.completions", n_wb, 4);
    @(posedge clk); #1;

    // Reset asserted while a store is on the memory port
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h020; bus.req_wdata = 32'h12345678; bus.req_rd = 5'd0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rstmid.issue_en", bus.dmem_en, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid.dmem_en", bus.dmem_en, 1'b0);
    chk("rstmid.dmem_addr", bus.dmem_addr, 8'h00);
    chk("rstmid.dmem_wdata", bus.dmem_wdata, 32'h0);
    chk("rstmid.ready", bus.req_ready, 1'b1);
    chk("rstmid.wb_valid", bus.wb_valid, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_req("lw20", 1'b0, 3'b010, 32'h020, 32'h0, 5'd3, 2'b00, 32'h0);
    run_req("lw40", 1'b0, 3'b010, 32'h040, 32'h0, 5'd4, 2'b00, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
